pc_gen_unit: RTL and testbench

//  Parametrised program-counter generator for the 5-stage pipelined core; replaces the bare PC register.

---
 rtl/pc_gen_unit.sv | 141 ++++++++++++++
 tb/tb_pc_gen_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: program-counter generator feeding the IF stage.
// Selects the next fetch address (sequential step, redirect, halt/resume)
// and presents it through a pc/pc_valid + fetch_ready handshake.
// Optional build macro: PC_MISALIGN_TRAP_EN -- misaligned redirect targets
// are trapped to TRAP_VECTOR with bad_addr/misalign_err reporting; without
// it the low alignment bits of the target are simply cleared.
module pc_gen_unit #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]      TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned          PC_STEP      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] bad_addr
);

  localparam int unsigned     ALIGN_BITS = $clog2(PC_STEP);
  localparam logic [XLEN-1:0] LOW_MASK   = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  // Elaboration-time sanity checks on the configuration.
  if (PC_STEP < 2 || (PC_STEP & (PC_STEP - 1)) != 0) begin : g_bad_step
    $error("pc_gen_unit: PC_STEP must be a power of two >= 2");
  end
  if ((TRAP_VECTOR & LOW_MASK) != '0) begin : g_bad_trap
    $error("pc_gen_unit: TRAP_VECTOR must be PC_STEP aligned");
  end

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] redir_pc;
  logic            redir_bad;

  // Resolve the address a redirect loads, and whether it is a trapped one.
  always_comb begin
    redir_bad = 1'b0;
    redir_pc  = redirect_target & ~LOW_MASK;
`ifdef PC_MISALIGN_TRAP_EN
    redir_bad = |(redirect_target & LOW_MASK);
    if (redir_bad) redir_pc = TRAP_VECTOR;
`endif
  end

  // Next-state and next-PC selection; redirect beats halt beats stall beats step.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;
    case (state_q)
      S_BOOT: begin
        state_d    = S_RUN;
        pc_valid_d = 1'b1;
        pc_d       = RESET_VECTOR;
      end
      S_RUN: begin
        if (redirect_valid) begin
          pc_d       = redir_pc;
          pc_valid_d = 1'b1;
          if (redir_bad) begin
            misalign_d = 1'b1;
            bad_addr_d = redirect_target;
          end
        end else if (halt_req) begin
          state_d    = S_HALT;
          pc_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pc_valid_q && fetch_ready) begin
          pc_d = pc_q + STEP;
        end
      end
      S_HALT: begin
        // Redirect and resume are independent here: both may act in one cycle.
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (redir_bad) begin
            misalign_d = 1'b1;
            bad_addr_d = redirect_target;
          end
        end
        if (resume) begin
          state_d    = S_RUN;
          pc_valid_d = 1'b1;
        end else begin
          pc_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_BOOT;
        pc_valid_d = 1'b0;
        pc_d       = RESET_VECTOR;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign halted       = (state_q == S_HALT);
  assign misalign_err = misalign_q;
  assign bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Testbench for pc_gen_unit: directed stimulus pushes expected outputs into
// per-instance queues; monitors pop and compare one entry per clock.
// Instance A: XLEN=32 defaults. Instance B: XLEN=8 for address wrap.
module tb_pc_gen_unit;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        h;
    logic        m;
    logic [31:0] bad;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Instance A signals
  logic        reset_a, stall_a, redir_a, halt_a, resume_a, ready_a;
  logic [31:0] target_a, pc_a, bad_a;
  logic        valid_a, halted_a, merr_a;

  // Instance B signals
  logic        reset_b, stall_b, redir_b, halt_b, resume_b, ready_b;
  logic [7:0]  target_b, pc_b, bad_b;
  logic        valid_b, halted_b, merr_b;

  pc_gen_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100), .PC_STEP(4)
  ) dut_a (
    .clk(clk), .reset(reset_a), .stall(stall_a), .redirect_valid(redir_a),
    .redirect_target(target_a), .halt_req(halt_a), .resume(resume_a),
    .fetch_ready(ready_a), .pc(pc_a), .pc_valid(valid_a), .halted(halted_a),
    .misalign_err(merr_a), .bad_addr(bad_a)
  );

  pc_gen_unit #(
    .XLEN(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80), .PC_STEP(4)
  ) dut_b (
    .clk(clk), .reset(reset_b), .stall(stall_b), .redirect_valid(redir_b),
    .redirect_target(target_b), .halt_req(halt_b), .resume(resume_b),
    .fetch_ready(ready_b), .pc(pc_b), .pc_valid(valid_b), .halted(halted_b),
    .misalign_err(merr_b), .bad_addr(bad_b)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic ea(input logic [31:0] p, input logic v, input logic h,
                    input logic m, input logic [31:0] bad);
    exp_t e;
    e.pc = p; e.v = v; e.h = h; e.m = m; e.bad = bad;
    q_a.push_back(e);
    @(negedge clk);
  endtask

  task automatic eb(input logic [31:0] p, input logic v);
    exp_t e;
    e.pc = p; e.v = v; e.h = 1'b0; e.m = 1'b0; e.bad = 32'h0;
    q_b.push_back(e);
    @(negedge clk);
  endtask

  // Monitor A: compare every registered output once per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_pc",       pc_a,           e.pc);
        chk("a_pc_valid", 32'(valid_a),   32'(e.v));
        chk("a_halted",   32'(halted_a),  32'(e.h));
        chk("a_misalign", 32'(merr_a),    32'(e.m));
        chk("a_bad_addr", bad_a,          e.bad);
      end
    end
  end

  // Monitor B: pc and pc_valid of the narrow instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_pc",       32'(pc_b),    e.pc);
        chk("b_pc_valid", 32'(valid_b), 32'(e.v));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic seq_a();
    logic [31:0] trap_bad;
`ifdef PC_MISALIGN_TRAP_EN
    trap_bad = 32'h102;
`else
    trap_bad = 32'h0;
`endif
    reset_a = 1'b0; stall_a = 1'b0; redir_a = 1'b0; target_a = '0;
    halt_a = 1'b0; resume_a = 1'b0; ready_a = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) ea(32'h0, 0, 0, 0, 0);
    // release: BOOT cycle shows pc_valid=0
    reset_a = 1'b1;
    #1 chk("a_boot_valid", 32'(valid_a), 32'h0);
    ea(32'h0, 1, 0, 0, 0);
    ea(32'h4, 1, 0, 0, 0);
    ea(32'h8, 1, 0, 0, 0);
    // back-pressure
    ready_a = 1'b0;
    for (int i = 0; i < 4; i++) ea(32'h8, 1, 0, 0, 0);
    ready_a = 1'b1;
    ea(32'hC, 1, 0, 0, 0);
    // redirect overrides stall, then stall alone holds
    stall_a = 1'b1; redir_a = 1'b1; target_a = 32'h200;
    ea(32'h200, 1, 0, 0, 0);
    redir_a = 1'b0;
    ea(32'h200, 1, 0, 0, 0);
    ea(32'h200, 1, 0, 0, 0);
    stall_a = 1'b0;
    ea(32'h204, 1, 0, 0, 0);
    redir_a = 1'b1; target_a = 32'h10;
    ea(32'h10, 1, 0, 0, 0);
    // halt, redirect while halted, resume
    redir_a = 1'b0; halt_a = 1'b1;
    ea(32'h10, 0, 1, 0, 0);
    halt_a = 1'b0;
    ea(32'h10, 0, 1, 0, 0);
    redir_a = 1'b1; target_a = 32'h40;
    ea(32'h40, 0, 1, 0, 0);
    redir_a = 1'b0; resume_a = 1'b1;
    ea(32'h40, 1, 0, 0, 0);
    resume_a = 1'b0;
    ea(32'h44, 1, 0, 0, 0);
    resume_a = 1'b1;
    ea(32'h48, 1, 0, 0, 0);
    // redirect beats halt_req in RUN
    resume_a = 1'b0; redir_a = 1'b1; target_a = 32'h80; halt_a = 1'b1;
    ea(32'h80, 1, 0, 0, 0);
    redir_a = 1'b0;
    ea(32'h80, 0, 1, 0, 0);
    // resume wins over halt_req in HALT
    resume_a = 1'b1;
    ea(32'h80, 1, 0, 0, 0);
    halt_a = 1'b0; resume_a = 1'b0;
    ea(32'h84, 1, 0, 0, 0);
    // misaligned redirect
    redir_a = 1'b1; target_a = 32'h102;
`ifdef PC_MISALIGN_TRAP_EN
    ea(32'h100, 1, 0, 1, trap_bad);
`else
    ea(32'h100, 1, 0, 0, trap_bad);
`endif
    redir_a = 1'b0;
    ea(32'h104, 1, 0, 0, trap_bad);
    // asynchronous reset mid-RUN
    #2 reset_a = 1'b0;
    #1;
    chk("a_async_pc",    pc_a,            32'h0);
    chk("a_async_valid", 32'(valid_a),    32'h0);
    chk("a_async_bad",   bad_a,           32'h0);
    @(negedge clk);
    ea(32'h0, 0, 0, 0, 0);
    reset_a = 1'b1;
    ea(32'h0, 1, 0, 0, 0);
    ea(32'h4, 1, 0, 0, 0);
  endtask

  task automatic seq_b();
    reset_b = 1'b0; stall_b = 1'b0; redir_b = 1'b0; target_b = '0;
    halt_b = 1'b0; resume_b = 1'b0; ready_b = 1'b1;
    @(negedge clk);
    eb(32'h0, 0);
    eb(32'h0, 0);
    reset_b = 1'b1;
    eb(32'h0, 1);
    eb(32'h4, 1);
    redir_b = 1'b1; target_b = 8'hFC;
    eb(32'hFC, 1);
    redir_b = 1'b0;
    eb(32'h00, 1);
    eb(32'h04, 1);
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    @(negedge clk);
    @(negedge clk);
    chk("a_queue_drained", 32'(q_a.size()), 32'h0);
    chk("b_queue_drained", 32'(q_b.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
